// File: rtl/div_defs.sv
// div_defs: shared state encoding and default sizes for the sequential divider.
package div_defs;
  localparam int DIV_WIDTH = 64;
  localparam int CNT_W = 7;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIN   = 2'd2,
    DZERO = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: one restoring-division trial subtraction of the shifted partial remainder minus the divisor.
module div_trial_sub #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);
  // A successful trial is always below the divisor, so the low WIDTH bits carry the whole difference.
  assign no_borrow = minuend >= {1'b0, subtrahend};
  assign diff = minuend[WIDTH-1:0] - subtrahend;
endmodule

// File: rtl/seq_divider64.sv
// seq_divider64: iterative restoring UDIV/SDIV, one quotient bit per cycle, signs fixed up on completion.
module seq_divider64 #(
  parameter int WIDTH = div_defs::DIV_WIDTH,
  parameter int CNT_W = div_defs::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div_defs::*;
  div_state_e state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, dq_q, dq_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0] diff, dvd_abs, dvs_abs;
  logic no_borrow;
  assign dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_abs = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
  div_trial_sub #(.WIDTH(WIDTH)) u_sub (
    .minuend   ({rem_q, dq_q[WIDTH-1]}),
    .subtrahend(dvs_q),
    .diff      (diff),
    .no_borrow (no_borrow)
  );
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    dq_d = dq_q;
    dvs_d = dvs_q;
    quot_d = quot_q;
    remo_d = remo_q;
    cnt_d = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    busy_d = busy_q;
    dz_d = dz_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (divisor == '0) begin
          state_d = DZERO;
          quot_d = '0;
          remo_d = dividend;
          dz_d = 1'b1;
          done_d = 1'b1;
        end else begin
          state_d = CALC;
          busy_d = 1'b1;
          dz_d = 1'b0;
          rem_d = '0;
          dq_d = dvd_abs;
          dvs_d = dvs_abs;
          cnt_d = CNT_W'(WIDTH);
          qneg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d = is_signed & dividend[WIDTH-1];
        end
      end
      CALC: if (cnt_q == '0) begin
        // Results are registered on the way into FIN so done and the values appear together.
        state_d = FIN;
        busy_d = 1'b0;
        done_d = 1'b1;
        quot_d = qneg_q ? -dq_q : dq_q;
        remo_d = rneg_q ? -rem_q : rem_q;
      end else begin
        rem_d = no_borrow ? diff : {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};
        dq_d = {dq_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      dq_q <= '0;
      dvs_q <= '0;
      quot_q <= '0;
      remo_q <= '0;
      cnt_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      dq_q <= dq_d;
      dvs_q <= dvs_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      cnt_q <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign quotient = quot_q;
  assign remainder = remo_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider64.sv
// tb_seq_divider64: random and directed divides checked every cycle against an arithmetic timing/result model.
module tb_seq_divider64;
  localparam int W = 64;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int checks = 0, failures = 0;
  seq_divider64 dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb;
    sa = a;
    sb = b;
    if (!s) return a / b;
    if (a == MIN && b == '1) return MIN;
    return W'(sa / sb);
  endfunction
  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb;
    sa = a;
    sb = b;
    if (!s) return a % b;
    if (a == MIN && b == '1) return '0;
    return W'(sa % sb);
  endfunction
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: an accepted request finishes WIDTH+2 cycles later; zero divisors finish the next cycle.
  logic m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  int m_left = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= '0; m_r <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_busy <= 1'b0; m_q <= p_q; m_r <= p_r;
        end
      end else if (!m_done && start) begin
        if (divisor == '0) begin
          m_done <= 1'b1; m_q <= '0; m_r <= dividend; m_dz <= 1'b1;
        end else begin
          p_q <= ref_q(dividend, divisor, is_signed);
          p_r <= ref_r(dividend, divisor, is_signed);
          m_busy <= 1'b1; m_dz <= 1'b0; m_left <= W + 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", W'(busy), W'(m_busy));
    chk("done", W'(done), W'(m_done));
    chk("div_by_zero", W'(div_by_zero), W'(m_dz));
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
  end
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input int inj, input bit noise, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      start = (lat == inj) || (noise && $urandom_range(3) == 0);
      dividend = (lat == inj) ? W'(9) : {$urandom, $urandom};
      divisor = (lat == inj) ? W'(3) : W'($urandom_range(5));
      is_signed = (lat == inj) ? 1'b0 : 1'($urandom_range(1));
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", W'(done), W'(1));
  endtask
  initial begin
    int lat;
    logic [W-1:0] a, b;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    reset = 1'b0;
    op(54, 17, 0, 0, 0, lat);
    chk("u54_17_lat", W'(lat), 66);
    chk("u54_17_q", quotient, 3);
    chk("u54_17_r", remainder, 3);
    chk("u54_17_busy", W'(busy), 0);
    op(-W'(54), 17, 1, 0, 0, lat);
    chk("sn54_17_q", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("sn54_17_r", remainder, 64'hFFFF_FFFF_FFFF_FFFD);
    op(54, -W'(17), 1, 0, 0, lat);
    chk("s54_n17_q", quotient, -W'(3));
    chk("s54_n17_r", remainder, 3);
    op(64'h1234, 0, 0, 0, 0, lat);
    chk("dz_lat", W'(lat), 1);
    chk("dz_q", quotient, 0);
    chk("dz_r", remainder, 64'h1234);
    chk("dz_flag", W'(div_by_zero), 1);
    op(MIN, '1, 1, 0, 0, lat);
    chk("sovf_q", quotient, MIN);
    chk("sovf_r", remainder, 0);
    chk("sovf_dz", W'(div_by_zero), 0);
    op(MIN, '1, 0, 0, 0, lat);
    chk("umin_q", quotient, 0);
    chk("umin_r", remainder, MIN);
    op(100, 7, 0, 10, 0, lat);
    chk("ign_lat", W'(lat), 66);
    chk("ign_q", quotient, 14);
    chk("ign_r", remainder, 2);
    op(9, 3, 0, 0, 0, lat);
    chk("b2b_lat", W'(lat), 66);
    chk("b2b_q", quotient, 3);
    chk("b2b_r", remainder, 0);
    op(0, 5, 1, 0, 0, lat);
    chk("zero_lat", W'(lat), 66);
    chk("zero_q", quotient, 0);
    a = {$urandom, $urandom};
    op(a, 1, 0, 0, 0, lat);
    chk("one_q", quotient, a);
    chk("one_r", remainder, 0);
    @(negedge clk);
    start = 1'b1; dividend = 12345; divisor = 11; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", W'(busy), 0);
    chk("arst_done", W'(done), 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      seen |= done;
    end
    chk("no_done_after_reset", W'(seen), 0);
    op(12345, 11, 0, 0, 0, lat);
    chk("post_rst_lat", W'(lat), 66);
    chk("post_rst_q", quotient, 1122);
    chk("post_rst_r", remainder, 3);
    repeat (30) begin
      case ($urandom_range(3))
        0: a = MIN;
        1: a = '0;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(5))
        0: b = '0;
        1: b = 1;
        2: b = '1;
        3: b = W'($urandom_range(1, 1000));
        4: b = W'($urandom);
        default: b = {$urandom, $urandom};
      endcase
      op(a, b, 1'($urandom_range(1)), 0, 1, lat);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_divider64.md
Name: seq_divider64

Overview:
- Iterative restoring divider for LEGv8 UDIV/SDIV in the execute stage.
- Sits directly upstream of the 64-bit subtractor datapath: each cycle it drives one trial subtraction (partial remainder minus divisor), consumes the difference and borrow, and shifts in one quotient bit.
- The ALU issues a request with `start` and stalls on `busy` until `done` pulses.

Parameters:
- WIDTH, 64, operand/result width in bits. Must be ≥ 2.
- CNT_W, 7, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- is_signed  in  1  1 = SDIV (two's complement), 0 = UDIV.
- dividend  in  WIDTH  numerator, sampled with start.
- divisor  in  WIDTH  denominator, sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- quotient  out  WIDTH  result, held until the next accepted start.
- remainder  out  WIDTH  result, held until the next accepted start.
- div_by_zero  out  1  set with done when divisor == 0; held with the results.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; counter = 0. An operation in flight is discarded; no done is issued for it.
- States:
  - IDLE → DZERO when start && divisor == 0.
  - IDLE → CALC when start && divisor != 0.
  - CALC → FIN when counter reaches 0.
  - FIN → IDLE unconditionally.
  - DZERO → IDLE unconditionally.
- Accept (IDLE with start = 1):
  - Latch operands.
  - If is_signed, latch absolute values plus sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Partial remainder = 0; counter = WIDTH; busy = 1 next cycle.
- CALC, each cycle:
  - Trial = {rem[WIDTH-1:0], dq[WIDTH-1]} − divisor, computed WIDTH+1 bits wide.
  - If no borrow: rem = trial, shift in quotient bit 1.
  - Else: rem unchanged except for the shift, quotient bit 0.
  - Counter decrements.
  - Exactly WIDTH iterations.
- FIN:
  - Apply signs: quotient negated if sign_q; remainder negated if sign_r (remainder takes the sign of the dividend, ARM semantics).
  - Register outputs; done = 1; busy = 0.
- Latency: start accepted in cycle 0 → done high in cycle WIDTH+2 (66 for WIDTH = 64). busy is high in cycles 1..WIDTH+1.
- DZERO:
  - quotient = 0, remainder = dividend (unmodified input bits), div_by_zero = 1, done = 1 in cycle 1; busy never asserts.
- Signed overflow (MIN / −1): quotient = MIN (wraps), remainder = 0, div_by_zero = 0. No trap.
- Unsigned operands with MSB set are treated as large positives; is_signed = 0 never negates.
- start while busy or during FIN/DZERO: ignored, not queued.
- Back-to-back: start may be asserted in the cycle after done (IDLE) and is accepted.
- Outputs change only at FIN/DZERO and at reset. div_by_zero clears at the next accepted start.
- Dividend 0: quotient 0, remainder 0, full latency (no early exit).
- Divisor 1: quotient = dividend, remainder 0.

Decomposition:
- Shared include/package div_defs:
  - State encodings IDLE = 0, CALC = 1, FIN = 2, DZERO = 3 (2-bit).
  - DIV_WIDTH = 64.
  - CNT_W = 7.
- One natural sub-module: div_trial_sub.
  - Combinational WIDTH+1-bit subtract of partial remainder minus divisor.
  - Outputs difference and no_borrow.
  - Instantiated once; keeps the FSM file purely sequential.

Test Plan:
- UDIV 54 / 17, is_signed = 0 → cycle 66: done = 1, quotient = 3, remainder = 3, div_by_zero = 0; busy low in cycle 66.
- SDIV −54 / 17 → quotient = 0xFFFF_FFFF_FFFF_FFFD (−3), remainder = 0xFFFF_FFFF_FFFF_FFFD (−3). SDIV 54 / −17 → quotient = −3, remainder = 3.
- Divide by zero: dividend = 0x1234, divisor = 0 → cycle 1: done = 1, quotient = 0, remainder = 0x1234, div_by_zero = 1; busy never high.
- SDIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → quotient = 0x8000_0000_0000_0000, remainder = 0. The same operands as UDIV → quotient = 0, remainder = 0x8000_0000_0000_0000.
- Start 100 / 7, then pulse start with 9 / 3 at cycle 10 → second request ignored; done at cycle 66 with quotient = 14, remainder = 2. Start 9 / 3 in cycle 67 → done at cycle 133, quotient = 3, remainder = 0.
- Assert reset in cycle 30 of an operation → busy, done, quotient, remainder = 0 immediately (asynchronous). No done pulse within 70 cycles after reset release. A new start after release completes normally.
